secded_syndrome_classifier: RTL

Registered, handshaked successor to the combinational error-count stage of the SECDED decoder. It normalises the received and recomputed parity vectors for the active codeword size, forms the syndrome, and classifies it as no error, single error or double error. It reports the bit position to correct through a one-deep valid/ready output register. It sits between the parity recompute stage and the bit-flip/correction stage, and adds error statistics and sticky double-error capture.

---
 rtl/secded_pkg.sv | 23 ++
 rtl/secded_parity_normalise.sv | 42 ++++
 rtl/secded_syndrome_classifier.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/secded_pkg.sv
// Shared constants for the SECDED syndrome classifier: classification codes,
// codeword-mode codes and the parity widths of the reduced codeword sizes.
package secded_pkg;

    typedef enum logic [1:0] {
        NOF_NONE    = 2'b00,
        NOF_SINGLE  = 2'b01,
        NOF_DOUBLE  = 2'b10,
        NOF_ILLEGAL = 2'b11
    } nof_e;

    typedef enum logic [1:0] {
        CW_SMALL   = 2'b00,
        CW_MEDIUM  = 2'b01,
        CW_LARGE   = 2'b10,
        CW_ILLEGAL = 2'b11
    } cw_mode_e;

    // Parity bits (overall bit included) of the reduced codeword sizes
    localparam int unsigned SMALL_PW  = 4;
    localparam int unsigned MEDIUM_PW = 5;

endpackage

// File: rtl/secded_parity_normalise.sv
// Mode-dependent remap of a parity vector: the low parity bits stay in place,
// unused middle bits are zeroed and the overall parity bit is moved to the MSB.
// Purely combinational; used once for received and once for recomputed parity.
module secded_parity_normalise
    import secded_pkg::*;
#(
    parameter int PARITY_WIDTH = 6
) (
    input  logic [1:0]              mode_i,
    input  logic [PARITY_WIDTH-1:0] par_i,
    output logic [PARITY_WIDTH-1:0] par_o
);

    // Widen to at least the medium size so the medium remap is always in range
    localparam int EXT_W = (PARITY_WIDTH > int'(MEDIUM_PW)) ? PARITY_WIDTH : int'(MEDIUM_PW);

    logic [EXT_W-1:0] par_ext_s;

    assign par_ext_s = EXT_W'(par_i);

    // Place the overall parity bit at the MSB and zero the bits the mode does not use
    always_comb begin
        par_o = {PARITY_WIDTH{1'b0}};
        case (cw_mode_e'(mode_i))
            CW_SMALL: begin
                par_o[SMALL_PW-2:0]    = par_ext_s[SMALL_PW-2:0];
                par_o[PARITY_WIDTH-1]  = par_ext_s[SMALL_PW-1];
            end
            CW_MEDIUM: begin
                par_o[MEDIUM_PW-2:0]   = par_ext_s[MEDIUM_PW-2:0];
                par_o[PARITY_WIDTH-1]  = par_ext_s[MEDIUM_PW-1];
            end
            CW_LARGE: begin
                par_o = par_ext_s[PARITY_WIDTH-1:0];
            end
            default: begin
                par_o = {PARITY_WIDTH{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/secded_syndrome_classifier.sv
// SECDED syndrome classifier: normalises received/recomputed parity for the
// active codeword size, forms the syndrome, classifies it (none / single /
// double / illegal mode) and presents the result through a one-deep
// valid/ready output register. Captures the tag of the first double error.
// Optional build macro SECDED_STATS_EN adds saturating per-class counters.
module secded_syndrome_classifier
    import secded_pkg::*;
#(
    parameter int PARITY_WIDTH = 6,
    parameter int CNT_WIDTH    = 16,
    parameter int TAG_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cw_mode,
    input  logic [PARITY_WIDTH-1:0] par_rx,
    input  logic [PARITY_WIDTH-1:0] par_calc,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              nof,
    output logic [PARITY_WIDTH-2:0] err_pos,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    dbl_sticky,
    output logic [TAG_WIDTH-1:0]    dbl_tag,
    input  logic                    stat_clr
`ifdef SECDED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    cnt_single,
    output logic [CNT_WIDTH-1:0]    cnt_double,
    output logic [CNT_WIDTH-1:0]    cnt_illegal
`endif
);

    // Classify a syndrome; result is {nof, err_pos}
    function automatic logic [PARITY_WIDTH:0] classify(
        input logic [1:0]              mode,
        input logic [PARITY_WIDTH-1:0] syn
    );
        logic                    ovr;
        logic [PARITY_WIDTH-2:0] low;
        ovr = syn[PARITY_WIDTH-1];
        low = syn[PARITY_WIDTH-2:0];
        if (cw_mode_e'(mode) == CW_ILLEGAL) begin
            classify = {NOF_ILLEGAL, {(PARITY_WIDTH-1){1'b0}}};
        end else if (ovr) begin
            // Odd overall parity: single error; low part 0 means the overall bit itself
            classify = {NOF_SINGLE, low};
        end else if (low != {(PARITY_WIDTH-1){1'b0}}) begin
            classify = {NOF_DOUBLE, low};
        end else begin
            classify = {NOF_NONE, {(PARITY_WIDTH-1){1'b0}}};
        end
    endfunction

    logic [PARITY_WIDTH-1:0] norm_rx_s;
    logic [PARITY_WIDTH-1:0] norm_calc_s;
    logic [PARITY_WIDTH-1:0] syn_s;
    logic [PARITY_WIDTH:0]   cls_s;
    logic [1:0]              cls_nof_s;
    logic [PARITY_WIDTH-2:0] cls_pos_s;
    logic                    xfer_s;

    logic                    out_valid_q,  out_valid_d;
    logic [1:0]              nof_q,        nof_d;
    logic [PARITY_WIDTH-2:0] err_pos_q,    err_pos_d;
    logic [TAG_WIDTH-1:0]    out_tag_q,    out_tag_d;
    logic                    dbl_sticky_q, dbl_sticky_d;
    logic [TAG_WIDTH-1:0]    dbl_tag_q,    dbl_tag_d;

    secded_parity_normalise #(.PARITY_WIDTH(PARITY_WIDTH)) u_norm_rx (
        .mode_i (cw_mode),
        .par_i  (par_rx),
        .par_o  (norm_rx_s)
    );

    secded_parity_normalise #(.PARITY_WIDTH(PARITY_WIDTH)) u_norm_calc (
        .mode_i (cw_mode),
        .par_i  (par_calc),
        .par_o  (norm_calc_s)
    );

    assign syn_s     = norm_rx_s ^ norm_calc_s;
    assign cls_s     = classify(cw_mode, syn_s);
    assign cls_nof_s = cls_s[PARITY_WIDTH:PARITY_WIDTH-1];
    assign cls_pos_s = cls_s[PARITY_WIDTH-2:0];

    assign in_ready  = ~out_valid_q | out_ready;
    assign xfer_s    = in_valid & in_ready;

    // Output register next state: load on transfer, drain when accepted, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        nof_d       = nof_q;
        err_pos_d   = err_pos_q;
        out_tag_d   = out_tag_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            nof_d       = cls_nof_s;
            err_pos_d   = cls_pos_s;
            out_tag_d   = in_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Sticky double-error capture; a same-cycle clear discards the new event
    always_comb begin
        dbl_sticky_d = dbl_sticky_q;
        dbl_tag_d    = dbl_tag_q;
        if (stat_clr) begin
            dbl_sticky_d = 1'b0;
            dbl_tag_d    = {TAG_WIDTH{1'b0}};
        end else if (xfer_s && (cls_nof_s == NOF_DOUBLE) && !dbl_sticky_q) begin
            dbl_sticky_d = 1'b1;
            dbl_tag_d    = in_tag;
        end else begin
            dbl_sticky_d = dbl_sticky_q;
        end
    end

    // State registers for the output stage and sticky capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            nof_q        <= NOF_NONE;
            err_pos_q    <= {(PARITY_WIDTH-1){1'b0}};
            out_tag_q    <= {TAG_WIDTH{1'b0}};
            dbl_sticky_q <= 1'b0;
            dbl_tag_q    <= {TAG_WIDTH{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            nof_q        <= nof_d;
            err_pos_q    <= err_pos_d;
            out_tag_q    <= out_tag_d;
            dbl_sticky_q <= dbl_sticky_d;
            dbl_tag_q    <= dbl_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign nof        = nof_q;
    assign err_pos    = err_pos_q;
    assign out_tag    = out_tag_q;
    assign dbl_sticky = dbl_sticky_q;
    assign dbl_tag    = dbl_tag_q;

`ifdef SECDED_STATS_EN
    // Increment that sticks at all-ones
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_WIDTH'(1'b1);
        end
    endfunction

    logic [CNT_WIDTH-1:0] cnt_single_q,  cnt_single_d;
    logic [CNT_WIDTH-1:0] cnt_double_q,  cnt_double_d;
    logic [CNT_WIDTH-1:0] cnt_illegal_q, cnt_illegal_d;

    // Per-class counter update; clear has priority over a same-cycle increment
    always_comb begin
        cnt_single_d  = cnt_single_q;
        cnt_double_d  = cnt_double_q;
        cnt_illegal_d = cnt_illegal_q;
        if (stat_clr) begin
            cnt_single_d  = {CNT_WIDTH{1'b0}};
            cnt_double_d  = {CNT_WIDTH{1'b0}};
            cnt_illegal_d = {CNT_WIDTH{1'b0}};
        end else if (xfer_s) begin
            case (nof_e'(cls_nof_s))
                NOF_SINGLE:  cnt_single_d  = sat_inc(cnt_single_q);
                NOF_DOUBLE:  cnt_double_d  = sat_inc(cnt_double_q);
                NOF_ILLEGAL: cnt_illegal_d = sat_inc(cnt_illegal_q);
                default:     cnt_single_d  = cnt_single_q;
            endcase
        end else begin
            cnt_single_d = cnt_single_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_single_q  <= {CNT_WIDTH{1'b0}};
            cnt_double_q  <= {CNT_WIDTH{1'b0}};
            cnt_illegal_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_single_q  <= cnt_single_d;
            cnt_double_q  <= cnt_double_d;
            cnt_illegal_q <= cnt_illegal_d;
        end
    end

    assign cnt_single  = cnt_single_q;
    assign cnt_double  = cnt_double_q;
    assign cnt_illegal = cnt_illegal_q;
`endif

endmodule
